bitmem_port_arbiter: RTL
========================

// Module: bitmem_port_arbiter
// PURPOSE
//  Shares one 16-entry x 1-bit memory (single sync write port, async read) between NUM_REQ requesters.
//  Round-robin arbiter: at most one access (read or write) per cycle.
//  Registers read data back to the granted requester.
//  After reset, runs an INIT sequence that zeroes every entry before accepting requests.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=2)
//  ADDR_W   4   memory address width; DEPTH = 2**ADDR_W = 16
//  CNT_W    8   grant-counter width (only with BITMEM_ARB_STATS_EN)
// PORTS
//  clk          in   1                  clock, all logic on posedge
//  rst          in   1                  synchronous, active-high reset
//  req_valid_i  in   NUM_REQ            request valid per requester
//  req_ready_o  out  NUM_REQ            request accepted this cycle (one-hot or zero)
//  req_we_i     in   NUM_REQ            1=write, 0=read
//  req_addr_i   in   NUM_REQ x ADDR_W   entry address
//  req_wdata_i  in   NUM_REQ            write data bit
//  rsp_valid_o  out  NUM_REQ            read response valid, one cycle after accept
//  rsp_rdata_o  out  1                  read data (shared, qualified by rsp_valid_o)
//  init_done_o  out  1                  1 once INIT has finished
//  mem_wen_o    out  1                  memory write enable
//  mem_waddr_o  out  ADDR_W             memory write address
//  mem_wdata_o  out  1                  memory write data
//  mem_raddr_o  out  ADDR_W             memory read address
//  mem_rdata_i  in   1                  memory read data (combinational from mem_raddr_o)
//  grant_cnt_o  out  NUM_REQ x CNT_W    accepted-request count per requester (BITMEM_ARB_STATS_EN only)
// BEHAVIOUR
//  Reset values
//   - state=INIT, init addr=0, rr pointer selects req 0 first.
//   - req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, init_done_o=0, grant_cnt_o=0.
//  FSM
//   - INIT: mem_wen_o=1, mem_wdata_o=0, mem_waddr_o=init addr; addr++ each cycle.
//     After writing addr DEPTH-1 (DEPTH cycles) -> RUN.
//     req_ready_o=0 throughout INIT.
//   - RUN: init_done_o=1 from the first RUN cycle; stays 1 until reset.
//  Arbitration (RUN only, combinational)
//   - Search valid requesters starting at rr_ptr; the first valid one is granted.
//   - req_ready_o[g]=1 for the granted requester only. Ready may depend on valid.
//   - Accept = valid & ready.
//   - On accept, rr_ptr <= (g+1) mod NUM_REQ. With no accept, rr_ptr holds.
//  Write accept
//   - mem_wen_o=1, mem_waddr_o=addr, mem_wdata_o=wdata, in the same cycle.
//   - Memory updates at the next posedge.
//  Read accept
//   - mem_raddr_o=addr in the same cycle.
//   - Next cycle: rsp_valid_o[g]=1 for one cycle; rsp_rdata_o=mem_rdata_i captured at that edge.
//   - rsp_rdata_o holds its value until the next read response.
//   - Read latency is exactly 1 cycle. Responses have no backpressure.
//  Idle outputs
//   - mem_wen_o=0 when there is no write.
//   - mem_raddr_o/mem_waddr_o = 0 when idle (don't-care, but deterministic).
//  Ordering
//   - Write to A in cycle N, then read of A in N+1: the read returns the new value.
//   - Read and write of A cannot share a cycle (one grant per cycle).
//  Reset mid-operation
//   - Any pending rsp_valid is dropped.
//   - Reset during INIT restarts INIT from addr 0.
//   - Reset during RUN re-runs INIT; memory contents are re-zeroed.
// CONFIGURATION
//  BITMEM_ARB_STATS_EN defined
//   - grant_cnt_o[i] increments on each accept by requester i.
//   - Wraps modulo 2**CNT_W; cleared by rst only.
//  BITMEM_ARB_STATS_EN undefined
//   - grant_cnt_o port and counters are absent; all other behaviour is identical.
// TESTING
//  - Reset, hold all req_valid_i=1 -> ready=0 for 16 cycles with mem_wen_o=1, wdata=0, addr 0..15;
//    init_done_o=1 on cycle 17.
//  - After INIT: req0 writes 1 to addr 5, then req0 reads addr 5 -> rsp_valid_o=2'b01 one cycle
//    after accept, rsp_rdata_o=1. Read of addr 6 -> 0.
//  - Both valid continuously in RUN -> grants alternate 0,1,0,1,...; no requester starved;
//    each rsp_valid goes only to the reader.
//  - Only req1 valid for 3 cycles -> ready[1]=1 each cycle; then both valid -> req0 granted first.
//  - Assert rst in the middle of a read accept -> no rsp_valid_o next cycle;
//    INIT restarts at addr 0 and addr 5 reads back 0 afterwards.
//  - STATS_EN, CNT_W=8: 256 grants to req0 -> grant_cnt_o[0] wraps to 0; grant_cnt_o[1] unaffected.

Source files
------------

// File: rtl/bitmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// bitmem_port_arbiter
//
// Shares one external DEPTH x 1-bit memory (one synchronous write port, one
// combinational read port) between NUM_REQ requesters. A round-robin arbiter
// grants at most one access (read or write) per cycle. Read data is registered
// and returned to the granted requester one cycle after acceptance. After
// reset an INIT sequence writes 0 to every entry before any request is taken.
//
// Optional feature: define BITMEM_ARB_STATS_EN to add per-requester grant
// counters (CNT_W bits, wrapping) on grant_cnt_o.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   req_valid_i    per-requester request valid
//   req_ready_o    one-hot (or zero) grant for this cycle
//   req_we_i       per-requester 1=write, 0=read
//   req_addr_i     per-requester entry address
//   req_wdata_i    per-requester write data bit
//   rsp_valid_o    one-hot read response valid, one cycle after accept
//   rsp_rdata_o    shared read data, held until the next read response
//   init_done_o    high once INIT has completed
//   mem_wen_o      memory write enable
//   mem_waddr_o    memory write address
//   mem_wdata_o    memory write data
//   mem_raddr_o    memory read address
//   mem_rdata_i    memory read data (combinational from mem_raddr_o)
//   grant_cnt_o    per-requester accept count (BITMEM_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module bitmem_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4
`ifdef BITMEM_ARB_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0]               req_we_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0]               req_wdata_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  output logic                             rsp_rdata_o,
  output logic                             init_done_o,
  output logic                             mem_wen_o,
  output logic [ADDR_W-1:0]                mem_waddr_o,
  output logic                             mem_wdata_o,
  output logic [ADDR_W-1:0]                mem_raddr_o,
  input  logic                             mem_rdata_i
`ifdef BITMEM_ARB_STATS_EN
  , output logic [NUM_REQ-1:0][CNT_W-1:0]  grant_cnt_o
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                 state_q;
  logic [ADDR_W-1:0]      init_addr_q;
  logic [PTR_W-1:0]       rr_ptr_q;
  logic [PTR_W-1:0]       rr_ptr_d;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic                   rsp_rdata_q;

  logic                   grant_vld;
  logic [PTR_W-1:0]       grant_idx;
  logic [NUM_REQ-1:0]     grant_oh;
  logic                   grant_we;

  // Requester index arithmetic modulo NUM_REQ (works for non-power-of-2 too).
  function automatic logic [PTR_W-1:0] wrap_idx(input int v);
    return PTR_W'(v % NUM_REQ);
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr_q wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q == ST_RUN && !grant_vld &&
          req_valid_i[wrap_idx(int'(rr_ptr_q) + i)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_idx(int'(rr_ptr_q) + i);
      end
    end
    grant_oh = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    grant_we = req_we_i[grant_idx];
    rr_ptr_d = grant_vld ? wrap_idx(int'(grant_idx) + 1) : rr_ptr_q;
  end

  // Memory port steering. Idle addresses are driven to 0 so the port is
  // deterministic even when nothing is accessed.
  always_comb begin
    mem_wen_o   = 1'b0;
    mem_waddr_o = '0;
    mem_wdata_o = 1'b0;
    mem_raddr_o = '0;
    if (state_q == ST_INIT) begin
      mem_wen_o   = 1'b1;
      mem_waddr_o = init_addr_q;
    end else if (grant_vld) begin
      if (grant_we) begin
        mem_wen_o   = 1'b1;
        mem_waddr_o = req_addr_i[grant_idx];
        mem_wdata_o = req_wdata_i[grant_idx];
      end else begin
        mem_raddr_o = req_addr_i[grant_idx];
      end
    end
  end

  assign req_ready_o = grant_oh;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign init_done_o = (state_q == ST_RUN);

  // Control FSM plus response register.
  // NOTE: the memory itself has no reset; its contents are cleared by the
  // INIT walk, which is why reset always re-enters ST_INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        ST_INIT: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_addr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          rr_ptr_q <= rr_ptr_d;
          // Read response: one cycle later, to the reader only.
          if (grant_vld && !grant_we) begin
            rsp_valid_q <= grant_oh;
            rsp_rdata_q <= mem_rdata_i;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

`ifdef BITMEM_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt_q;

  // Accept counters wrap naturally at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_oh[i]) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

endmodule
